// File: rtl/core_boot_pkg.sv
// Shared definitions for the core boot/run controller: state encoding and
// default parameter values used by core_boot_ctrl and run_watchdog.
package core_boot_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int ADDR_W_DEF   = 10;
   localparam int RST_HOLD_DEF = 4;
   localparam int CNT_W_DEF    = 32;

   typedef enum logic [2:0] {
      ST_IDLE = 3'd0,
      ST_LOAD = 3'd1,
      ST_HOLD = 3'd2,
      ST_RUN  = 3'd3,
      ST_DONE = 3'd4
   } boot_state_e;

endpackage

// File: rtl/run_watchdog.sv
// Run-phase watchdog: saturating cycle counter, timeout compare and the
// halt-over-timeout priority decision. A timeout budget of 0 means unlimited.
module run_watchdog
   import core_boot_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             count_en,
   input  logic             halt,
   input  logic [CNT_W-1:0] timeout_cycles,
   output logic [CNT_W-1:0] count,
   output logic             halt_hit,
   output logic             timeout_hit
);

   logic [CNT_W-1:0] count_inc;
   logic             limit_reached;

   // Next count value and end-of-run decision; halt always takes priority.
   always_comb begin
      count_inc     = count;
      limit_reached = 1'b0;
      if (&count) begin
         count_inc = count;
      end else begin
         count_inc = count + CNT_W'(1);
      end
      limit_reached = (timeout_cycles != {CNT_W{1'b0}}) && (count_inc == timeout_cycles);
      halt_hit      = count_en && halt;
      timeout_hit   = count_en && !halt && limit_reached;
   end

   // Run-cycle counter: cleared on a new load, advanced every RUN cycle.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         count <= {CNT_W{1'b0}};
      end else if (clear) begin
         count <= {CNT_W{1'b0}};
      end else if (count_en) begin
         count <= count_inc;
      end else begin
         count <= count;
      end
   end

endmodule

// File: rtl/core_boot_ctrl.sv
// Load-run-report controller for the RV32I core: streams a program into
// instruction memory, holds the core in reset for RST_HOLD cycles, runs it and
// reports halt/timeout. Optional feature macro: LOADER_CHECKSUM_EN (sum of
// accepted load words on the checksum port; constant 0 when undefined).
module core_boot_ctrl
   import core_boot_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int ADDR_W   = ADDR_W_DEF,
   parameter int RST_HOLD = RST_HOLD_DEF,
   parameter int CNT_W    = CNT_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic              abort,
   input  logic              ld_valid,
   input  logic [DATA_W-1:0] ld_data,
   input  logic              ld_last,
   output logic              ld_ready,
   output logic              imem_we,
   output logic [ADDR_W-1:0] imem_addr,
   output logic [DATA_W-1:0] imem_wdata,
   output logic              core_rst_n,
   output logic              core_en,
   input  logic              halt,
   input  logic [CNT_W-1:0]  timeout_cycles,
   output logic              busy,
   output logic              done,
   output logic              pass,
   output logic              timeout_err,
   output logic              overflow,
   output logic [ADDR_W:0]   load_count,
   output logic [CNT_W-1:0]  cycle_count,
   output logic [DATA_W-1:0] checksum
);

   localparam int HOLD_W = $clog2(RST_HOLD + 1);
   localparam logic [ADDR_W-1:0] PTR_MAX = {ADDR_W{1'b1}};

   boot_state_e       state;
   boot_state_e       state_next;
   logic [ADDR_W-1:0] wr_ptr;
   logic [HOLD_W-1:0] hold_cnt;
   logic              handshake;
   logic              clear;
   logic              ptr_full;
   logic              run_active;
   logic              halt_hit;
   logic              timeout_hit;

   // State-decoded outputs and the zero-latency write path into imem.
   always_comb begin
      ld_ready   = (state == ST_LOAD);
      handshake  = ld_ready && ld_valid;
      imem_we    = handshake;
      imem_addr  = wr_ptr;
      if (state == ST_LOAD) begin
         imem_wdata = ld_data;
      end else begin
         imem_wdata = {DATA_W{1'b0}};
      end
      run_active = (state == ST_RUN);
      core_en    = run_active;
      core_rst_n = run_active || (state == ST_DONE);
      busy       = (state == ST_LOAD) || (state == ST_HOLD) || run_active;
      done       = (state == ST_DONE);
      ptr_full   = (wr_ptr == PTR_MAX);
      clear      = start && !abort && ((state == ST_IDLE) || (state == ST_DONE));
   end

   // Next-state logic; abort overrides every other event.
   always_comb begin
      state_next = state;
      if (abort) begin
         state_next = ST_IDLE;
      end else begin
         case (state)
            ST_IDLE, ST_DONE: begin
               if (start) state_next = ST_LOAD;
               else       state_next = state;
            end
            ST_LOAD: begin
               // Filling the last address ends the load even without ld_last.
               if (handshake && (ld_last || ptr_full)) state_next = ST_HOLD;
               else                                    state_next = ST_LOAD;
            end
            ST_HOLD: begin
               if (hold_cnt == HOLD_W'(RST_HOLD - 1)) state_next = ST_RUN;
               else                                   state_next = ST_HOLD;
            end
            ST_RUN: begin
               if (halt_hit || timeout_hit) state_next = ST_DONE;
               else                         state_next = ST_RUN;
            end
            default: state_next = ST_IDLE;
         endcase
      end
   end

   // State register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= ST_IDLE;
      else      state <= state_next;
   end

   // Reset-hold timer: counts HOLD cycles, idles at zero elsewhere.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                   hold_cnt <= {HOLD_W{1'b0}};
      else if (state == ST_HOLD)  hold_cnt <= hold_cnt + HOLD_W'(1);
      else                        hold_cnt <= {HOLD_W{1'b0}};
   end

   // Load bookkeeping: write pointer (saturates, never wraps), count, overflow.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr     <= {ADDR_W{1'b0}};
         load_count <= {(ADDR_W+1){1'b0}};
         overflow   <= 1'b0;
      end else if (clear) begin
         wr_ptr     <= {ADDR_W{1'b0}};
         load_count <= {(ADDR_W+1){1'b0}};
         overflow   <= 1'b0;
      end else if (handshake) begin
         load_count <= load_count + (ADDR_W+1)'(1);
         if (!ptr_full) wr_ptr <= wr_ptr + ADDR_W'(1);
         if (ptr_full && !ld_last) overflow <= 1'b1;
      end
   end

   // Result flags, held through DONE and after abort until the next start.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         pass        <= 1'b0;
         timeout_err <= 1'b0;
      end else if (clear) begin
         pass        <= 1'b0;
         timeout_err <= 1'b0;
      end else if (run_active && !abort) begin
         if (halt_hit)    pass        <= 1'b1;
         if (timeout_hit) timeout_err <= 1'b1;
      end
   end

`ifdef LOADER_CHECKSUM_EN
   // Modulo-2^DATA_W sum of every accepted load word.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst)           checksum <= {DATA_W{1'b0}};
      else if (clear)     checksum <= {DATA_W{1'b0}};
      else if (handshake) checksum <= checksum + ld_data;
   end
`else
   assign checksum = {DATA_W{1'b0}};
`endif

   run_watchdog #(
      .CNT_W (CNT_W)
   ) u_watchdog (
      .clk            (clk),
      .rst            (rst),
      .clear          (clear),
      .count_en       (run_active),
      .halt           (halt),
      .timeout_cycles (timeout_cycles),
      .count          (cycle_count),
      .halt_hit       (halt_hit),
      .timeout_hit    (timeout_hit)
   );

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Self-checking bench for core_boot_ctrl. A default instance runs a table of
// load/run scenarios; a second ADDR_W=2 instance sharing the same stimulus
// covers memory overflow. Checksum expectation follows LOADER_CHECKSUM_EN.
module tb_core_boot_ctrl;

   logic        clk = 1'b0;
   logic        rst, start, abort, ld_valid, ld_last, halt;
   logic [31:0] ld_data, timeout_cycles;

   logic        ld_ready, imem_we, core_rst_n, core_en, busy, done, pass, timeout_err, overflow;
   logic [9:0]  imem_addr;
   logic [31:0] imem_wdata, cycle_count, checksum;
   logic [10:0] load_count;

   logic        sm_ld_ready, sm_imem_we, sm_core_rst_n, sm_core_en, sm_busy, sm_done;
   logic        sm_pass, sm_timeout_err, sm_overflow;
   logic [1:0]  sm_imem_addr;
   logic [31:0] sm_imem_wdata, sm_cycle_count, sm_checksum;
   logic [2:0]  sm_load_count;

   always #5 clk = ~clk;

   core_boot_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last), .ld_ready(ld_ready), .imem_we(imem_we),
      .imem_addr(imem_addr), .imem_wdata(imem_wdata), .core_rst_n(core_rst_n),
      .core_en(core_en), .halt(halt), .timeout_cycles(timeout_cycles), .busy(busy),
      .done(done), .pass(pass), .timeout_err(timeout_err), .overflow(overflow),
      .load_count(load_count), .cycle_count(cycle_count), .checksum(checksum)
   );

   core_boot_ctrl #(.ADDR_W(2)) dut_small (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .ld_valid(ld_valid),
      .ld_data(ld_data), .ld_last(ld_last), .ld_ready(sm_ld_ready), .imem_we(sm_imem_we),
      .imem_addr(sm_imem_addr), .imem_wdata(sm_imem_wdata), .core_rst_n(sm_core_rst_n),
      .core_en(sm_core_en), .halt(halt), .timeout_cycles(timeout_cycles), .busy(sm_busy),
      .done(sm_done), .pass(sm_pass), .timeout_err(sm_timeout_err), .overflow(sm_overflow),
      .load_count(sm_load_count), .cycle_count(sm_cycle_count), .checksum(sm_checksum)
   );

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: logs imem writes, last-word handshake time, core_en rise and on-time.
   int          cyc = 0, nwr = 0, nwr_s = 0, last_hs_cyc = 0, rise_cyc = 0, en_total = 0;
   logic        prev_en = 1'b0;
   logic [9:0]  wr_addr   [0:255];
   logic [31:0] wr_data   [0:255];
   logic [1:0]  wr_addr_s [0:63];

   always @(negedge clk) begin
      cyc <= cyc + 1;
      if (imem_we) begin
         if (nwr < 256) begin
            wr_addr[nwr] <= imem_addr;
            wr_data[nwr] <= imem_wdata;
         end
         nwr <= nwr + 1;
      end
      if (sm_imem_we) begin
         if (nwr_s < 64) wr_addr_s[nwr_s] <= sm_imem_addr;
         nwr_s <= nwr_s + 1;
      end
      if (ld_valid && ld_ready && ld_last) last_hs_cyc <= cyc;
      if (core_en && !prev_en) rise_cyc <= cyc;
      if (core_en) en_total <= en_total + 1;
      prev_en <= core_en;
   end

   logic [31:0] prog [0:7];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic load(input int n, input bit with_last, input bit gaps);
      for (int i = 0; i < n; i++) begin
         if (gaps) begin
            ld_valid = 1'b0;
            ld_data  = 32'hDEAD_BEEF;
            tick();
         end
         ld_valid = 1'b1;
         ld_data  = prog[i];
         ld_last  = with_last && (i == n - 1);
         tick();
      end
      ld_valid = 1'b0;
      ld_last  = 1'b0;
      ld_data  = 32'h0;
   endtask

   task automatic wait_run(input int halt_at, output bit ok);
      int run_idx;
      run_idx = 0;
      ok = 1'b0;
      for (int k = 0; k < 400; k++) begin
         if (done) begin
            ok = 1'b1;
            break;
         end
         if (core_en) begin
            run_idx++;
            halt = (halt_at != 0) && (run_idx == halt_at);
         end else begin
            halt = 1'b0;
         end
         tick();
      end
      halt = 1'b0;
   endtask

   typedef struct {
      logic [31:0] timeout;
      int          halt_at;
      logic [31:0] exp_cycles;
      logic        exp_pass;
      logic        exp_to;
      int          exp_en;
   } vec_t;

   vec_t vecs [0:3];

   initial begin
      int  w0, w0s, e0;
      bit  ok;
      rst = 1'b0; start = 1'b0; abort = 1'b0; ld_valid = 1'b0; ld_last = 1'b0;
      halt = 1'b0; ld_data = 32'h0; timeout_cycles = 32'h0;

      vecs[0] = '{32'd100, 5,  32'd5,  1'b1, 1'b0, 5};
      vecs[1] = '{32'd20,  0,  32'd20, 1'b0, 1'b1, 20};
      vecs[2] = '{32'd10,  10, 32'd10, 1'b1, 1'b0, 10};
      vecs[3] = '{32'd0,   37, 32'd37, 1'b1, 1'b0, 37};

      // Reset state.
      #12;
      chk("rst_core_rst_n", core_rst_n, 0);
      chk("rst_ld_ready", ld_ready, 0);
      chk("rst_busy_done", {busy, done, core_en}, 0);
      chk("rst_flags", {pass, timeout_err, overflow}, 0);
      chk("rst_counts", {load_count, cycle_count}, 0);
      @(posedge clk); #1;
      rst = 1'b1;
      tick();

      prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0000_0073;

      // Table-driven load/run scenarios with the 3-word program.
      for (int v = 0; v < 4; v++) begin
         w0 = nwr;
         e0 = en_total;
         timeout_cycles = vecs[v].timeout;
         pulse_start();
         chk($sformatf("v%0d_cleared", v), {pass, timeout_err, load_count, cycle_count}, 0);
         chk($sformatf("v%0d_busy_load", v), {busy, ld_ready}, 2'b11);
         load(3, 1'b1, 1'b0);
         chk($sformatf("v%0d_load_count", v), load_count, 3);
         chk($sformatf("v%0d_nwrites", v), nwr - w0, 3);
         for (int i = 0; i < 3; i++) begin
            chk($sformatf("v%0d_addr%0d", v, i), wr_addr[w0 + i], i);
            chk($sformatf("v%0d_data%0d", v, i), wr_data[w0 + i], prog[i]);
         end
         chk($sformatf("v%0d_hold_rst", v), {core_rst_n, core_en}, 2'b00);
         wait_run(vecs[v].halt_at, ok);
         chk($sformatf("v%0d_done_reached", v), ok, 1);
         chk($sformatf("v%0d_en_latency", v), rise_cyc - last_hs_cyc, 5);
         chk($sformatf("v%0d_cycle_count", v), cycle_count, vecs[v].exp_cycles);
         chk($sformatf("v%0d_pass", v), pass, vecs[v].exp_pass);
         chk($sformatf("v%0d_timeout_err", v), timeout_err, vecs[v].exp_to);
         chk($sformatf("v%0d_en_cycles", v), en_total - e0, vecs[v].exp_en);
         chk($sformatf("v%0d_done_outs", v), {done, busy, core_en, core_rst_n}, 4'b1001);
      end

      // Overflow on the ADDR_W=2 instance: 6 words, no ld_last.
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ov_idle", {busy, sm_busy}, 0);
      for (int i = 0; i < 6; i++) prog[i] = 32'h100 + i;
      w0s = nwr_s;
      pulse_start();
      load(6, 1'b0, 1'b0);
      chk("ov_nwrites", nwr_s - w0s, 4);
      for (int i = 0; i < 4; i++) chk($sformatf("ov_addr%0d", i), wr_addr_s[w0s + i], i);
      chk("ov_flag", sm_overflow, 1);
      chk("ov_load_count", sm_load_count, 4);
      chk("ov_in_hold", {sm_busy, sm_ld_ready, sm_core_rst_n, sm_core_en}, 4'b1000);
      chk("ov_big_no_overflow", {overflow, load_count}, {1'b0, 11'd6});
      abort = 1'b1;
      tick();
      abort = 1'b0;
      chk("ov_abort_idle", {sm_busy, busy}, 0);
      chk("ov_flag_holds", sm_overflow, 1);

      // Gapped ld_valid, then abort (with halt) during RUN.
      prog[0] = 32'h0050_0093; prog[1] = 32'h00A0_0113; prog[2] = 32'h0000_0073;
      timeout_cycles = 32'd1000;
      w0 = nwr;
      pulse_start();
      load(3, 1'b1, 1'b1);
      chk("gap_nwrites", nwr - w0, 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("gap_addr%0d", i), wr_addr[w0 + i], i);
         chk($sformatf("gap_data%0d", i), wr_data[w0 + i], prog[i]);
      end
      ok = 1'b0;
      for (int k = 0; k < 20; k++) begin
         if (core_en) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      chk("ab_reached_run", ok, 1);
      tick();
      abort = 1'b1;
      halt  = 1'b1;
      tick();
      abort = 1'b0;
      halt  = 1'b0;
      chk("ab_idle", {busy, done, core_en, core_rst_n}, 0);
      chk("ab_beats_halt", {pass, timeout_err}, 0);

      // Asynchronous reset in the middle of a load, then reload.
      for (int i = 0; i < 3; i++) prog[i] = i + 1;
      pulse_start();
      ld_valid = 1'b1; ld_data = 32'd1; tick();
      ld_data = 32'd2; tick();
      chk("mid_load_count", load_count, 2);
      #2 rst = 1'b0;
      #1;
      chk("arst_ready_we", {ld_ready, imem_we}, 0);
      chk("arst_outs", {busy, done, core_rst_n, core_en}, 0);
      chk("arst_counts", {load_count, imem_addr, imem_wdata, checksum}, 0);
      ld_valid = 1'b0; ld_data = 32'h0;
      tick();
      rst = 1'b1;
      tick();
      w0 = nwr;
      pulse_start();
      load(3, 1'b1, 1'b0);
      chk("reload_nwrites", nwr - w0, 3);
      for (int i = 0; i < 3; i++) begin
         chk($sformatf("reload_addr%0d", i), wr_addr[w0 + i], i);
         chk($sformatf("reload_data%0d", i), wr_data[w0 + i], i + 1);
      end
`ifdef LOADER_CHECKSUM_EN
      chk("checksum", checksum, 6);
`else
      chk("checksum", checksum, 0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
